// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shift unit.
// Widths, op codes and FSM state encoding.
package seq_shift_pkg;

  localparam int SHIFT_WIDTH = 8;
  localparam int SHIFT_AMT_W = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_ROL = 2'b01,
    OP_SRL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Single-bit combinational shift/rotate step.
// Right-direction ops exist only with SEQ_SHIFT_RIGHT_EN.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0] i_data,
  input  shift_op_t        i_op,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    unique case (i_op)
      OP_SLL: o_data = {i_data[WIDTH-2:0], 1'b0};
      OP_ROL: o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
`ifdef SEQ_SHIFT_RIGHT_EN
      OP_SRL: o_data = {1'b0, i_data[WIDTH-1:1]};
      OP_ROR: o_data = {i_data[0], i_data[WIDTH-1:1]};
`else
      OP_SRL, OP_ROR: o_data = i_data;
`endif
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/seq_left_shift_unit.sv
// One-bit-per-cycle SLL/ROL unit with START/DONE handshake.
// SEQ_SHIFT_RIGHT_EN adds SRL/ROR on OP=10/11.
module seq_left_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int AMT_W = SHIFT_AMT_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] OPERAND,
  input  logic [AMT_W-1:0] AMOUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  shift_state_t     r_state;
  shift_op_t        r_op;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_result;

  shift_op_t        w_op;
  logic [WIDTH-1:0] w_load;
  logic [AMT_W-1:0] w_eff;
  logic [WIDTH-1:0] w_step;
  logic             w_ready;
  logic             w_over;
  logic [AMT_W-1:0] w_wrap;

  assign w_op    = shift_op_t'(OP);
  assign w_ready = (r_state == ST_IDLE) ||
                   (r_state == ST_DONE);
  assign w_over  = AMOUNT >= AMT_W'(WIDTH);
  assign w_wrap  = AMOUNT & AMT_W'(WIDTH - 1);

  // Logical over-range shifts resolve at accept with no iteration.
  always_comb begin
    w_load = OPERAND;
    w_eff  = '0;
    unique case (w_op)
      OP_SLL: begin
        w_load = w_over ? '0 : OPERAND;
        w_eff  = w_over ? '0 : AMOUNT;
      end
      OP_ROL: w_eff = w_wrap;
`ifdef SEQ_SHIFT_RIGHT_EN
      OP_SRL: begin
        w_load = w_over ? '0 : OPERAND;
        w_eff  = w_over ? '0 : AMOUNT;
      end
      OP_ROR: w_eff = w_wrap;
`else
      OP_SRL, OP_ROR: w_eff = '0;
`endif
      default: w_eff = '0;
    endcase
  end

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_data (r_shreg),
    .i_op   (r_op),
    .o_data (w_step)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_SLL;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (START && w_ready) begin
            r_op    <= w_op;
            r_shreg <= w_load;
            r_cnt   <= w_eff;
            if (w_eff == '0) begin
              r_state  <= ST_DONE;
              r_result <= w_load;
            end else begin
              r_state <= ST_SHIFT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_shreg <= w_step;
          r_cnt   <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state  <= ST_DONE;
            r_result <= w_step;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY   = (r_state == ST_SHIFT);
  assign DONE   = (r_state == ST_DONE);
  assign RESULT = r_result;

endmodule
